// File: rtl/faccel_pkg.sv
// Shared definitions for the factorial-accelerator master: register map,
// controller state encoding and a counter-width helper.
package faccel_pkg;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_N,
        WR_GO,
        CLR_GO,
        POLL,
        READ,
        RESP
    } state_t;

    // Width needed to hold 0..limit, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/faccel_if.sv
// Host request/response handshake plus the accelerator register bus.
interface faccel_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_n;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        bus_we;
    logic [1:0]  bus_a;
    logic [3:0]  bus_d;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_n, resp_ready, bus_rdata,
        output req_ready, resp_valid, resp_data, resp_err,
        output bus_we, bus_a, bus_d
    );

    modport slave (
        output req_valid, req_n, resp_ready, bus_rdata,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  bus_we, bus_a, bus_d
    );

endinterface

// File: rtl/faccel_master_poll_timer.sv
// Clearable, saturating poll counter; tc flags the last permitted poll.
module poll_timer
    import faccel_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = cnt_width(LIMIT);

    logic [W-1:0] count;

    // Count enabled cycles, holding at LIMIT so the value never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != W'(LIMIT))) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(LIMIT - 1));

endmodule

// File: rtl/faccel_master.sv
// Sequences one factorial job on the accelerator: write N, pulse GO,
// poll STATUS with a timeout, read RESULT, then hold the response.
module faccel_master
    import faccel_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned MAX_N   = 12
) (
    input  logic     clk,
    input  logic     rst,
    faccel_if.master io
);

    state_t state;
    logic   timer_clr;
    logic   timer_en;
    logic   timer_tc;

    // Counter restarts while GO is being written and advances on each idle poll.
    always_comb begin
        timer_clr = (state == WR_GO);
        timer_en  = (state == POLL) && !io.bus_rdata[0] && !timer_tc;
    end

    poll_timer #(
        .LIMIT (TIMEOUT)
    ) u_poll_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (timer_tc)
    );

    // Controller; every output is registered together with the next state,
    // so the bus lines are a pure function of the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            io.req_ready  <= 1'b1;
            io.resp_valid <= 1'b0;
            io.resp_data  <= '0;
            io.resp_err   <= 1'b0;
            io.bus_we     <= 1'b0;
            io.bus_a      <= ADDR_N;
            io.bus_d      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.req_valid) begin
                        io.req_ready <= 1'b0;
                        if ({28'd0, io.req_n} > MAX_N) begin
                            state         <= RESP;
                            io.resp_valid <= 1'b1;
                            io.resp_err   <= 1'b1;
                            io.resp_data  <= '0;
                        end else begin
                            // bus_d doubles as the captured operand
                            state     <= WR_N;
                            io.bus_we <= 1'b1;
                            io.bus_a  <= ADDR_N;
                            io.bus_d  <= io.req_n;
                        end
                    end
                end
                WR_N: begin
                    state     <= WR_GO;
                    io.bus_we <= 1'b1;
                    io.bus_a  <= ADDR_GO;
                    io.bus_d  <= 4'b0001;
                end
                WR_GO: begin
                    state     <= CLR_GO;
                    io.bus_we <= 1'b1;
                    io.bus_a  <= ADDR_GO;
                    io.bus_d  <= 4'b0000;
                end
                CLR_GO: begin
                    state     <= POLL;
                    io.bus_we <= 1'b0;
                    io.bus_a  <= ADDR_STATUS;
                    io.bus_d  <= '0;
                end
                POLL: begin
                    if (io.bus_rdata[0]) begin
                        state    <= READ;
                        io.bus_a <= ADDR_RESULT;
                    end else if (timer_tc) begin
                        state         <= RESP;
                        io.bus_a      <= ADDR_N;
                        io.resp_valid <= 1'b1;
                        io.resp_err   <= 1'b1;
                        io.resp_data  <= '0;
                    end
                end
                READ: begin
                    state         <= RESP;
                    io.bus_a      <= ADDR_N;
                    io.resp_valid <= 1'b1;
                    io.resp_err   <= 1'b0;
                    io.resp_data  <= io.bus_rdata;
                end
                RESP: begin
                    if (io.resp_ready) begin
                        state         <= IDLE;
                        io.resp_valid <= 1'b0;
                        io.req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    io.req_ready  <= 1'b1;
                    io.resp_valid <= 1'b0;
                    io.bus_we     <= 1'b0;
                    io.bus_a      <= ADDR_N;
                    io.bus_d      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_faccel_master.sv
// Directed bench for faccel_master with a simple accelerator responder.
module tb_faccel_master;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    faccel_if io ();

    faccel_master #(
        .TIMEOUT (255),
        .MAX_N   (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int tests = 0;
    int fails = 0;

    // accelerator model state
    logic [3:0]  acc_n    = '0;
    logic        acc_done = 1'b0;
    logic [31:0] acc_res  = '0;
    int          acc_cnt  = 0;
    int          poll_delay  = 0;
    bit          hold_status = 1'b0;

    // bus observation
    int          wr_count = 0;
    logic [1:0]  wr_a [8];
    logic [3:0]  wr_d [8];
    int          polls = 0;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // Register read port of the accelerator.
    always_comb begin
        case (io.bus_a)
            2'd2:    io.bus_rdata = {31'd0, acc_done & ~hold_status};
            2'd3:    io.bus_rdata = acc_res;
            default: io.bus_rdata = '0;
        endcase
    end

    // Accelerator register writes and job timing; also logs each write.
    always @(posedge clk) begin
        if (io.bus_we) begin
            if (wr_count < 8) begin
                wr_a[wr_count] = io.bus_a;
                wr_d[wr_count] = io.bus_d;
            end
            wr_count = wr_count + 1;
        end
        if (io.bus_we && io.bus_a == 2'd0) acc_n <= io.bus_d;
        if (io.bus_we && io.bus_a == 2'd1 && io.bus_d[0]) begin
            acc_res  <= fact(acc_n);
            acc_cnt  <= poll_delay + 1;
            acc_done <= 1'b0;
        end else if (acc_cnt > 0) begin
            acc_cnt <= acc_cnt - 1;
            if (acc_cnt == 1) acc_done <= 1'b1;
        end
    end

    // Count STATUS poll cycles.
    always @(posedge clk) begin
        if (rst && !io.bus_we && io.bus_a == 2'd2) polls = polls + 1;
    end

    task automatic start_job(input logic [3:0] n);
        bit ok;
        @(negedge clk);
        wr_count = 0;
        polls = 0;
        io.req_n = n;
        io.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (io.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_wait: req_ready got 0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1 io.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        bit ok;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (io.resp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL resp_wait: resp_valid got 0 expected 1 within 400 cycles");
        end
    endtask

    task automatic consume();
        io.resp_ready = 1'b1;
        @(posedge clk);
        #1 io.resp_ready = 1'b0;
    endtask

    task automatic run_job(input logic [3:0] n, input int delay, input bit hold,
                           output logic [31:0] data, output logic err, output int lat);
        poll_delay  = delay;
        hold_status = hold;
        start_job(n);
        wait_resp(lat);
        data = io.resp_data;
        err  = io.resp_err;
        consume();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (io.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid: got %b expected 0", io.resp_valid); end
        tests++; if (io.resp_data !== 32'd0) begin fails++; $display("FAIL rst_resp_data: got %0d expected 0", io.resp_data); end
        tests++; if (io.resp_err !== 1'b0) begin fails++; $display("FAIL rst_resp_err: got %b expected 0", io.resp_err); end
        tests++; if (io.bus_we !== 1'b0) begin fails++; $display("FAIL rst_bus_we: got %b expected 0", io.bus_we); end
        tests++; if (io.bus_a !== 2'd0) begin fails++; $display("FAIL rst_bus_a: got %0d expected 0", io.bus_a); end
        tests++; if (io.bus_d !== 4'd0) begin fails++; $display("FAIL rst_bus_d: got %0d expected 0", io.bus_d); end
        tests++; if (io.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %b expected 1", io.req_ready); end
        rst = 1'b1;
    endtask

    task automatic test_n5();
        logic [31:0] d; logic e; int lat;
        run_job(4'd5, 0, 1'b0, d, e, lat);
        tests++; if (wr_count !== 3) begin fails++; $display("FAIL n5_wr_count: got %0d expected 3", wr_count); end
        tests++; if (wr_a[0] !== 2'd0 || wr_d[0] !== 4'd5) begin fails++; $display("FAIL n5_wr0: got a=%0d d=%0d expected a=0 d=5", wr_a[0], wr_d[0]); end
        tests++; if (wr_a[1] !== 2'd1 || wr_d[1] !== 4'd1) begin fails++; $display("FAIL n5_wr1: got a=%0d d=%0d expected a=1 d=1", wr_a[1], wr_d[1]); end
        tests++; if (wr_a[2] !== 2'd1 || wr_d[2] !== 4'd0) begin fails++; $display("FAIL n5_wr2: got a=%0d d=%0d expected a=1 d=0", wr_a[2], wr_d[2]); end
        tests++; if (d !== 32'd120) begin fails++; $display("FAIL n5_data: got %0d expected 120", d); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL n5_err: got %b expected 0", e); end
        tests++; if (lat !== 6) begin fails++; $display("FAIL n5_latency: got %0d expected 6", lat); end
        tests++; if (polls !== 1) begin fails++; $display("FAIL n5_polls: got %0d expected 1", polls); end
    endtask

    task automatic test_bounds();
        logic [31:0] d; logic e; int lat;
        run_job(4'd0, 0, 1'b0, d, e, lat);
        tests++; if (d !== 32'd1 || e !== 1'b0) begin fails++; $display("FAIL n0_result: got %0d err=%b expected 1 err=0", d, e); end
        run_job(4'd12, 0, 1'b0, d, e, lat);
        tests++; if (d !== 32'd479001600 || e !== 1'b0) begin fails++; $display("FAIL n12_result: got %0d err=%b expected 479001600 err=0", d, e); end
        tests++; if (lat !== 6) begin fails++; $display("FAIL n12_latency: got %0d expected 6", lat); end
    endtask

    task automatic test_reject();
        logic [31:0] d; logic e; int lat;
        run_job(4'd13, 0, 1'b0, d, e, lat);
        tests++; if (wr_count !== 0) begin fails++; $display("FAIL n13_wr_count: got %0d expected 0", wr_count); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL n13_latency: got %0d expected 1", lat); end
        tests++; if (d !== 32'd0 || e !== 1'b1) begin fails++; $display("FAIL n13_result: got %0d err=%b expected 0 err=1", d, e); end
    endtask

    task automatic test_extra_polls();
        logic [31:0] d; logic e; int lat;
        run_job(4'd6, 3, 1'b0, d, e, lat);
        tests++; if (d !== 32'd720 || e !== 1'b0) begin fails++; $display("FAIL slow_result: got %0d err=%b expected 720 err=0", d, e); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL slow_latency: got %0d expected 9", lat); end
        tests++; if (polls !== 4) begin fails++; $display("FAIL slow_polls: got %0d expected 4", polls); end
    endtask

    task automatic test_timeout();
        logic [31:0] d; logic e; int lat;
        run_job(4'd9, 0, 1'b1, d, e, lat);
        tests++; if (polls !== 255) begin fails++; $display("FAIL to_polls: got %0d expected 255", polls); end
        tests++; if (d !== 32'd0 || e !== 1'b1) begin fails++; $display("FAIL to_result: got %0d err=%b expected 0 err=1", d, e); end
        tests++; if (lat !== 259) begin fails++; $display("FAIL to_latency: got %0d expected 259", lat); end
        tests++; if (wr_count !== 3) begin fails++; $display("FAIL to_wr_count: got %0d expected 3", wr_count); end
        hold_status = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        poll_delay  = 0;
        hold_status = 1'b0;
        start_job(4'd4);
        wait_resp(lat);
        io.req_valid = 1'b1;
        io.req_n = 4'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (io.resp_valid !== 1'b1 || io.resp_data !== 32'd24 || io.resp_err !== 1'b0) begin
                fails++; $display("FAIL bp_hold: got v=%b d=%0d e=%b expected v=1 d=24 e=0", io.resp_valid, io.resp_data, io.resp_err); end
            tests++; if (io.req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready: got %b expected 0", io.req_ready); end
            tests++; if (io.bus_we !== 1'b0) begin fails++; $display("FAIL bp_bus_we: got %b expected 0", io.bus_we); end
        end
        tests++; if (wr_count !== 3) begin fails++; $display("FAIL bp_wr_count: got %0d expected 3", wr_count); end
        io.resp_ready = 1'b1;
        @(posedge clk);
        #1 io.resp_ready = 1'b0;
        wr_count = 0;
        polls = 0;
        @(negedge clk);
        tests++; if (io.req_ready !== 1'b1 || io.resp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", io.req_ready, io.resp_valid); end
        tests++; if (wr_count !== 0) begin fails++; $display("FAIL bp_no_early_accept: got %0d writes expected 0", wr_count); end
        @(posedge clk);
        #1 io.req_valid = 1'b0;
        wait_resp(lat);
        tests++; if (io.resp_data !== 32'd6 || io.resp_err !== 1'b0) begin
            fails++; $display("FAIL b2b_result: got %0d err=%b expected 6 err=0", io.resp_data, io.resp_err); end
        tests++; if (lat !== 6) begin fails++; $display("FAIL b2b_latency: got %0d expected 6", lat); end
        consume();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic e; int lat;
        hold_status = 1'b1;
        start_job(4'd7);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (polls >= 5) break;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++; if (io.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_resp_valid: got %b expected 0", io.resp_valid); end
        tests++; if (io.bus_we !== 1'b0) begin fails++; $display("FAIL mid_bus_we: got %b expected 0", io.bus_we); end
        tests++; if (io.req_ready !== 1'b1 || io.bus_a !== 2'd0) begin
            fails++; $display("FAIL mid_idle: got ready=%b bus_a=%0d expected ready=1 bus_a=0", io.req_ready, io.bus_a); end
        @(negedge clk);
        rst = 1'b1;
        run_job(4'd7, 0, 1'b0, d, e, lat);
        tests++; if (d !== 32'd5040 || e !== 1'b0) begin fails++; $display("FAIL mid_next_result: got %0d err=%b expected 5040 err=0", d, e); end
        tests++; if (lat !== 6) begin fails++; $display("FAIL mid_next_latency: got %0d expected 6", lat); end
    endtask

    initial begin
        io.req_valid  = 1'b0;
        io.req_n      = '0;
        io.resp_ready = 1'b0;
        test_reset();
        test_n5();
        test_bounds();
        test_reject();
        test_extra_polls();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/faccel_master.md
FACCEL_MASTER -- requirements
Module: faccel_master

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of status-poll cycles per job before the job is abandoned.
REQ-002 Parameter MAX_N, default 12: largest operand accepted, since 12! is the largest factorial that fits in 32 bits.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 req_valid  in  1  host presents a job.
REQ-006 req_ready  out  1  master can accept a job.
REQ-007 req_n  in  4  operand n.
REQ-008 resp_valid  out  1  result available.
REQ-009 resp_ready  in  1  host consumes the result.
REQ-010 resp_data  out  32  n! or 0 on error.
REQ-011 resp_err  out  1  1 means n>MAX_N or timeout.
REQ-012 bus_we  out  1  accelerator write strobe.
REQ-013 bus_a  out  2  register address: 0=N, 1=GO, 2=STATUS, 3=RESULT.
REQ-014 bus_d  out  4  write data.
REQ-015 bus_rdata  in  32  combinational read data for the current bus_a.

Function
REQ-016 The FSM states SHALL be IDLE, WR_N, WR_GO, CLR_GO, POLL, READ and RESP.
REQ-017 IDLE: req_ready=1; on req_valid, capture req_n; if req_n>MAX_N go to RESP with err=1 and data=0, else go to WR_N.
REQ-018 WR_N SHALL drive bus_we=1, bus_a=0, bus_d=captured n, then go to WR_GO.
REQ-019 WR_GO SHALL drive bus_we=1, bus_a=1, bus_d=4'b0001, clear the poll counter, then go to CLR_GO.
REQ-020 CLR_GO SHALL drive bus_we=1, bus_a=1, bus_d=4'b0000 (deassert GO; d[0]=0 starts no job), then go to POLL.
REQ-021 POLL SHALL drive bus_we=0, bus_a=2 and act on bus_rdata[0] as follows:
- bus_rdata[0]=1: go to READ.
- otherwise, counter==TIMEOUT-1: go to RESP with err=1, data=0.
- otherwise: increment the counter and stay in POLL.
REQ-022 READ SHALL drive bus_we=0, bus_a=3, latch bus_rdata into resp_data with err=0, then go to RESP.
REQ-023 RESP: resp_valid=1; resp_data and resp_err stay stable until resp_valid&&resp_ready, then go to IDLE.
REQ-024 req_ready SHALL be 0 in every state except IDLE, and a request is not accepted in the same cycle as a response handshake.
REQ-025 In IDLE, RESP and POLL/READ, bus_we SHALL be 0; bus_a and bus_d are don't-care except bus_we=0.
REQ-026 Bus outputs SHALL be decoded from registered state only (Moore), with no combinational path from bus_rdata to bus outputs.
REQ-027 A valid job (n≤MAX_N, status set on the first poll) has a latency of 6 cycles from accept to resp_valid; each additional poll adds 1 cycle.
REQ-028 n=0 SHALL be legal and return 1; n=MAX_N SHALL be accepted, and n=MAX_N+1 SHALL be rejected with no bus write.
REQ-029 The poll counter width SHALL be clog2(TIMEOUT+1) and SHALL never wrap within a job.

Reset
REQ-030 While rst=0 at a clock edge: state=IDLE, counter=0, resp_valid=0, resp_data=0, resp_err=0, bus_we=0, bus_a=0, bus_d=0.
REQ-031 Reset mid-job SHALL abandon the job without a response; bus_we=0 from the next cycle.

Structure
REQ-032 Package faccel_pkg SHALL hold the address constants ADDR_N/ADDR_GO/ADDR_STATUS/ADDR_RESULT and the state enum.
REQ-033 The design SHALL have one sub-module, poll_timer, a clearable, saturating counter with a terminal-count flag.

Verification
REQ-034 Responder model, n=5 -> writes N=5, GO=1, GO=0; resp_data=120, err=0.
REQ-035 n=0 and n=12 -> resp_data=1 and 479001600, err=0.
REQ-036 n=13 -> no bus_we pulse; resp_valid 1 cycle after accept, err=1, data=0.
REQ-037 Status held 0 -> exactly 255 POLL cycles, then err=1, data=0.
REQ-038 resp_ready held low 10 cycles, with req_valid=1 -> data stable, req_ready=0, no new bus activity.
REQ-039 rst=0 during POLL -> IDLE next cycle, resp_valid=0, bus_we=0; next job completes normally.
